// File: rtl/ks_mem_responder_if.sv
// Request/ack bus and boot-loader stream between the K&S core and its 32x16 RAM responder.
interface ks_mem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;
    logic              ram_busy;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata, load_valid, load_data, load_last,
        input  ram_rdata, ram_ack, ram_busy, load_ready, load_done
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata, load_valid, load_data, load_last,
        output ram_rdata, ram_ack, ram_busy, load_ready, load_done
    );
endinterface

// File: rtl/ks_mem_responder.sv
// Memory-side responder for the K&S RAM port: fixed-latency req/ack access plus a boot-loader
// stream that fills the array from address 0.
module ks_mem_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WR_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ks_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              ack;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ptr_d     = ptr_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        ack       = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = bus.load_data;

        unique case (state_q)
            IDLE: begin
                // Loader wins; a coincident request waits for the next IDLE cycle.
                if (bus.load_valid) begin
                    mem_we = 1'b1;
                    if (bus.load_last) begin
                        ptr_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else if (bus.ram_req) begin
                    addr_d  = bus.ram_addr;
                    wdata_d = bus.ram_wdata;
                    if (bus.ram_we) begin
                        state_d = WR_WAIT;
                        cnt_d   = 4'(WR_LATENCY);
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 4'(RD_LATENCY);
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (state_q == WR_WAIT) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_q;
                        mem_wdata = wdata_q;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Array has no reset so contents survive rst_n; write enables are already gated by the FSM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // rdata_d already carries mem[addr] in the read-ack cycle and the held value otherwise.
    assign bus.ram_rdata  = rdata_d;
    assign bus.ram_ack    = ack;
    assign bus.ram_busy   = (state_q != IDLE);
    assign bus.load_ready = (state_q == IDLE);
    assign bus.load_done  = done_q;

endmodule

// File: tb/tb_ks_mem_responder.sv
// Scoreboard bench for ks_mem_responder: directed loads and requests, ack data checked by a monitor.
module tb_ks_mem_responder;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 5;
    localparam int unsigned RDL = 2;
    localparam int unsigned WRL = 1;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    exp_t          exp_q[$];
    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    ks_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ks_mem_responder #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .RD_LATENCY(RDL),
        .WR_LATENCY(WRL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack consumes one expectation and checks the presented read data.
    always @(negedge clk) begin
        exp_t e;
        if (bus.ram_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_ack: ack seen with no pending request (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk(e.we ? "wr_ack_rdata_held" : "rd_data", 32'(bus.ram_rdata), 32'(e.rdata));
            end
        end
    end

    task automatic push_exp(input logic we, input logic [DW-1:0] rd);
        exp_t e;
        e.we    = we;
        e.rdata = we ? last_rd : rd;
        exp_q.push_back(e);
        if (!we) last_rd = rd;
    endtask

    task automatic load_word(input logic [DW-1:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        @(negedge clk);
        chk("load_ready_idle", 32'(bus.load_ready), 32'd1);
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        @(negedge clk);
        chk("load_done", 32'(bus.load_done), 32'(last));
        @(posedge clk); #1;
    endtask

    // Issued from IDLE, so acceptance is the first edge; checks busy/ack cycle by cycle.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rd, input bit with_load);
        int unsigned lat;
        lat = we ? WRL : RDL;
        push_exp(we, exp_rd);
        bus.ram_req   = 1'b1;
        bus.ram_we    = we;
        bus.ram_addr  = addr;
        bus.ram_wdata = wdata;
        @(posedge clk); #1;
        if (with_load) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 16'hAAAA;
            bus.load_last  = 1'b0;
        end
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy_in_flight", 32'(bus.ram_busy), 32'd1);
            chk("ack_timing", 32'(bus.ram_ack), 32'(k == lat));
            if (with_load) chk("load_ready_busy", 32'(bus.load_ready), 32'd0);
            if (k == lat) begin
                bus.ram_req    = 1'b0;
                bus.load_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.ram_busy), 32'd0);
        chk("idle_ack", 32'(bus.ram_ack), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.ram_req    = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_wdata  = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        last_rd        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", 32'(bus.ram_rdata), 32'd0);
        chk("rst_ack", 32'(bus.ram_ack), 32'd0);
        chk("rst_busy", 32'(bus.ram_busy), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_load_done", 32'(bus.load_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Boot load and read latency
        load_word(16'h8141, 1'b0);
        load_word(16'h2222, 1'b0);
        load_word(16'hFFFF, 1'b1);
        do_req(1'b0, 5'd2, '0, 16'hFFFF, 1'b0);
        do_req(1'b0, 5'd1, '0, 16'h2222, 1'b0);
        do_req(1'b0, 5'd0, '0, 16'h8141, 1'b0);

        // Write then read back; write ack presents the held read value
        do_req(1'b1, 5'd31, 16'h1234, '0, 1'b0);
        do_req(1'b0, 5'd31, '0, 16'h1234, 1'b0);

        // Contention: load and read of addr 0 together; load must land first
        push_exp(1'b0, 16'h5555);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h5555;
        bus.load_last  = 1'b1;
        bus.ram_req    = 1'b1;
        bus.ram_we     = 1'b0;
        bus.ram_addr   = 5'd0;
        @(negedge clk);
        chk("cont_load_ready", 32'(bus.load_ready), 32'd1);
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        @(negedge clk);
        chk("cont_not_busy", 32'(bus.ram_busy), 32'd0);
        chk("cont_load_done", 32'(bus.load_done), 32'd1);
        @(posedge clk); #1;
        for (int unsigned k = 1; k <= RDL; k++) begin
            @(negedge clk);
            chk("cont_busy", 32'(bus.ram_busy), 32'd1);
            chk("cont_ack_timing", 32'(bus.ram_ack), 32'(k == RDL));
            if (k == RDL) bus.ram_req = 1'b0;
        end
        @(posedge clk); #1;
        // Loader held during a busy read must not write mem[ptr=0]
        do_req(1'b0, 5'd1, '0, 16'h2222, 1'b1);
        do_req(1'b0, 5'd0, '0, 16'h5555, 1'b0);

        // Reset during a pending write
        load_word(16'h8141, 1'b0);
        load_word(16'h2222, 1'b0);
        load_word(16'hFFFF, 1'b0);
        load_word(16'h0003, 1'b0);
        load_word(16'h0004, 1'b0);
        load_word(16'h0000, 1'b1);
        bus.ram_req   = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = 5'd5;
        bus.ram_wdata = 16'hBEEF;
        @(posedge clk); #1;
        rst_n       = 1'b0;
        bus.ram_req = 1'b0;
        bus.ram_we  = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 32'(bus.ram_ack), 32'd0);
        chk("midrst_busy", 32'(bus.ram_busy), 32'd0);
        chk("midrst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("midrst_rdata", 32'(bus.ram_rdata), 32'd0);
        chk("midrst_load_done", 32'(bus.load_done), 32'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        last_rd = '0;
        @(posedge clk); #1;
        do_req(1'b0, 5'd5, '0, 16'h0000, 1'b0);
        do_req(1'b0, 5'd4, '0, 16'h0004, 1'b0);

        // Loader wrap: 33 words, no last; word 33 lands at addr 0, pointer ends at 1
        for (int unsigned i = 0; i < 33; i++) begin
            load_word(16'(16'h1000 + i), 1'b0);
        end
        do_req(1'b0, 5'd0, '0, 16'h1020, 1'b0);
        do_req(1'b0, 5'd1, '0, 16'h1001, 1'b0);
        do_req(1'b0, 5'd31, '0, 16'h101F, 1'b0);
        load_word(16'h7777, 1'b1);
        do_req(1'b0, 5'd1, '0, 16'h7777, 1'b0);
        do_req(1'b0, 5'd2, '0, 16'h1002, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
